unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-port, variable-latency backing memory between the pipeline's instruction-fetch port and its data-memory port. It sits between the IF/MEM stages and the memory model, replacing the separate instruction and data memories. It serialises accesses with data-first priority and a starvation guard for fetch. It returns per-port acknowledges that the pipeline uses as stall-release.

## Interface
- ADDR_W, 32, byte address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- STARVE_LIM, 4, consecutive data grants allowed while fetch waits; must be ≥1
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  DATA_W  fetch data, valid with i_ack, held until next fetch completion
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wstrb  in  DATA_W/8  byte enables for writes
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  read data, valid with d_ack on reads, held otherwise
- m_req  out  1  memory request, held until m_done
- m_we, m_addr, m_wdata, m_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered command fields
- m_done  in  1  memory completion, may assert in the first m_req cycle
- m_rdata  in  DATA_W  valid with m_done
- i_stall, d_stall  out  1  i_req & ~i_ack, d_req & ~d_ack (combinational)

## Operation
- FSM states: IDLE, BUSY, RESP; owner register ∈ {FETCH, DATA}.
- IDLE: if d_req and not starve, grant DATA. Else if i_req, grant FETCH. Else stay in IDLE.
- starve = i_req & (starve_cnt == STARVE_LIM).
- On a grant, latch the owner's command into the m_* registers and go to BUSY.
- Fetch commands drive m_we = 0 and m_wstrb = 0.
- BUSY: m_req = 1. On m_done, capture m_rdata into the owner's rdata register and go to RESP.
  - d_rdata is updated only for reads. On a data write, m_rdata is ignored.
- RESP: assert the owner's ack for one cycle, drop m_req, then go to IDLE.
- The one-cycle RESP→IDLE gap keeps the arbiter from re-sampling a req that is still high in the ack cycle.
- Starvation counter, width $clog2(STARVE_LIM+1):
  - DATA grant with i_req high: increment, saturating at STARVE_LIM.
  - FETCH grant: clear to 0.
  - DATA grant with i_req low: clear to 0.
- Changes on i_req or d_req during BUSY or RESP are ignored until IDLE.
- Requester fields are sampled only at grant.

## Timing
- Reset values: state IDLE, owner FETCH, starve_cnt 0.
- All outputs reset to 0: m_req, m_we, m_addr, m_wdata, m_wstrb, i_ack, d_ack, i_rdata, d_rdata.
- Reset asserted mid-transaction: m_req and the acks drop asynchronously. The abandoned memory access must be tolerated by the memory model, and no ack is issued for it.
- Latency: req seen in IDLE at cycle 0 → m_req high from cycle 1. m_done in cycle k ≥ 1 → ack in cycle k+1 → IDLE in cycle k+2.
- Minimum req-to-ack is 2 cycles. Minimum issue-to-issue spacing is 3 cycles.
- Simultaneous i_req and d_req in IDLE: DATA wins unless starve is true.
- i_ack and d_ack are never high in the same cycle. m_req is never high in RESP.
- m_* fields are constant while m_req is high.

## Structure
- Package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_BUSY, ARB_RESP}
  - typedef enum arb_owner_t {OWN_FETCH, OWN_DATA}
  - typedef struct mem_cmd_t {we, addr, wdata, wstrb}
- One sub-module, mem_arb_pick: combinational grant decision from i_req, d_req and starve_cnt. All state lives in unified_mem_arbiter.

## Test plan
- Single fetch: i_req, i_addr=0x10, m_done in cycle 1 with m_rdata=0x00000013 → i_ack in cycle 2 with i_rdata=0x13, d_ack stays 0.
- Contention: i_req and d_req both rise in the same IDLE cycle, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF.
  - Required: the write issues first; the fetch issues 3 cycles later; d_rdata is unchanged.
- Starvation with STARVE_LIM=4: i_req held continuously while d_req is re-asserted right after each d_ack.
  - Required: exactly 4 data grants, then a fetch grant, then the counter returns to 0.
- Long latency: m_done delayed 7 cycles → m_req and m_addr stable for all 7 cycles, i_stall high throughout, ack exactly once.
- Reset mid-BUSY: reset low in cycle 2 of a data read → m_req drops in the same cycle, no d_ack. After reset release, a new fetch completes normally.
- Zero-wait back-to-back: m_done tied high, 10 fetches → acks every 3 cycles, i_rdata matches the address sequence.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified fetch/data memory arbiter.
// Widths here size the latched memory command; the top defaults to them.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } arb_owner_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_STRB_W-1:0] wstrb;
  } mem_cmd_t;

  // Starvation counter width: must hold the value STARVE_LIM itself.
  function automatic int starve_cnt_w(input int lim);
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and backing-memory port of the unified arbiter.
// slave = arbiter side, master = pipeline plus memory model side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_done, m_rdata,
    output i_ack, i_rdata, i_stall,
    output d_ack, d_rdata, d_stall,
    output m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_done, m_rdata,
    input  i_ack, i_rdata, i_stall,
    input  d_ack, d_rdata, d_stall,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb
  );

endinterface

// File: rtl/unified_mem_arbiter_pick.sv
// Combinational grant decision: data first, fetch forced once it has watched
// STARVE_LIM consecutive data grants. Zero latency, no state.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic             i_req_i,
  input  logic             d_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             grant_vld_o,
  output arb_owner_t       grant_owner_o
);

  logic starve;

  always_comb begin
    grant_vld_o   = 1'b0;
    grant_owner_o = OWN_FETCH;
    starve        = i_req_i && (starve_cnt_i == CNT_W'(STARVE_LIM));
    if (d_req_i && !starve) begin
      grant_vld_o   = 1'b1;
      grant_owner_o = OWN_DATA;
    end else if (i_req_i) begin
      grant_vld_o   = 1'b1;
      grant_owner_o = OWN_FETCH;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port.
// Req-to-ack >= 2 cycles, issue spacing >= 3; requests wait until IDLE.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = starve_cnt_w(STARVE_LIM);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              grant_vld;
  arb_owner_t        grant_owner;
  logic              i_ack, d_ack;

  mem_arb_pick #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_pick (
    .i_req_i       (bus.i_req),
    .d_req_i       (bus.d_req),
    .starve_cnt_i  (starve_cnt_q),
    .grant_vld_o   (grant_vld),
    .grant_owner_o (grant_owner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_FETCH;
      starve_cnt_q <= '0;
      cmd_q        <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      cmd_q        <= cmd_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    cmd_d        = cmd_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_owner;
          state_d = ARB_BUSY;
          if (grant_owner == OWN_DATA) begin
            cmd_d.we    = bus.d_we;
            cmd_d.addr  = MEM_ADDR_W'(bus.d_addr);
            cmd_d.wdata = MEM_DATA_W'(bus.d_wdata);
            cmd_d.wstrb = MEM_STRB_W'(bus.d_wstrb);
            // Count only data grants the fetch port actually had to watch.
            if (!bus.i_req) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_W'(STARVE_LIM)) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end else begin
            cmd_d.we     = 1'b0;
            cmd_d.addr   = MEM_ADDR_W'(bus.i_addr);
            cmd_d.wdata  = '0;
            cmd_d.wstrb  = '0;
            starve_cnt_d = '0;
          end
        end
      end

      ARB_BUSY: begin
        if (bus.m_done) begin
          state_d = ARB_RESP;
          if (owner_q == OWN_FETCH) begin
            i_rdata_d = m_rdata_w();
          end else if (!cmd_q.we) begin
            d_rdata_d = m_rdata_w();
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  function automatic logic [DATA_W-1:0] m_rdata_w();
    return bus.m_rdata;
  endfunction

  // Acks and m_req decode straight from state so an async reset drops them at once.
  assign i_ack = (state_q == ARB_RESP) && (owner_q == OWN_FETCH);
  assign d_ack = (state_q == ARB_RESP) && (owner_q == OWN_DATA);

  assign bus.i_ack   = i_ack;
  assign bus.d_ack   = d_ack;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_stall = bus.i_req & ~i_ack;
  assign bus.d_stall = bus.d_req & ~d_ack;

  assign bus.m_req   = (state_q == ARB_BUSY);
  assign bus.m_we    = cmd_q.we;
  assign bus.m_addr  = ADDR_W'(cmd_q.addr);
  assign bus.m_wdata = DATA_W'(cmd_q.wdata);
  assign bus.m_wstrb = STRB_W'(cmd_q.wstrb);

  a_ack_excl : assert property (@(posedge clock) disable iff (!reset)
    !(i_ack && d_ack));

  a_ack_pulse : assert property (@(posedge clock) disable iff (!reset)
    (i_ack || d_ack) |=> !(i_ack || d_ack));

  a_cmd_stable : assert property (@(posedge clock) disable iff (!reset)
    (bus.m_req && $past(bus.m_req)) |-> $stable(cmd_q));

  a_no_req_in_resp : assert property (@(posedge clock) disable iff (!reset)
    (state_q == ARB_RESP) |-> !bus.m_req);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference memory (updated when stimulus is issued) and device memory
  // (updated by the memory model when it completes a command).
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] dev_mem [int unsigned];
  logic [31:0] exp_i [$];
  logic [31:0] exp_d [$];
  logic [31:0] exp_d_last = '0;
  int          mem_lat = 0;

  bit          grant_log [$];
  int          issue_cyc [$];
  int          mreq_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    return ref_mem.exists(k) ? ref_mem[k] : init_word({a[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    return dev_mem.exists(k) ? dev_mem[k] : init_word({a[31:2], 2'b00});
  endfunction

  // ---------------- requester tasks (called at a negedge) ----------------
  task automatic do_fetch(input logic [31:0] a);
    int n;
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    exp_i.push_back(ref_rd(a));
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.i_ack && n < 300);
    if (!bus.i_ack) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: no i_ack for addr %0h after %0d cycles", a, n);
    end
    bus.i_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
    int n;
    logic [31:0] v;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_wstrb = ws;
    bus.d_req   = 1'b1;
    if (we) begin
      ref_mem[a >> 2] = merge(ref_rd(a), wd, ws);
      exp_d.push_back(exp_d_last);
    end else begin
      v = ref_rd(a);
      exp_d.push_back(v);
      exp_d_last = v;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.d_ack && n < 300);
    if (!bus.d_ack) begin
      checks++;
      errors++;
      $display("FAIL data_timeout: no d_ack for addr %0h after %0d cycles", a, n);
    end
    bus.d_req = 1'b0;
  endtask

  // ---------------- memory model ----------------
  initial begin
    int cnt;
    int lat;
    bit busy;
    logic [31:0] old;
    cnt = 0; lat = 0; busy = 1'b0;
    bus.m_done  = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clock);
      if (!reset || !bus.m_req) begin
        bus.m_done = 1'b0;
        busy = 1'b0;
        cnt = 0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
        if (cnt == lat) begin
          bus.m_done = 1'b1;
          old = dev_rd(bus.m_addr);
          if (bus.m_we) begin
            dev_mem[bus.m_addr >> 2] = merge(old, bus.m_wdata, bus.m_wstrb);
            bus.m_rdata = $urandom;
          end else begin
            bus.m_rdata = old;
          end
        end else begin
          bus.m_done = 1'b0;
        end
        cnt++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic s_i_req, s_d_req, s_d_we, s_m_done;
    logic [31:0] s_i_addr, s_d_addr, s_d_wdata;
    logic [3:0] s_d_wstrb;
    logic last_m_req, last_we, last_ack;
    logic [31:0] last_addr, last_wdata;
    logic [3:0] last_wstrb;
    bit idle_prev, idle_now, new_iss, exp_ack, want_data, owner_data;
    int wait_cnt, cyc;
    last_m_req = 0; last_ack = 0; idle_prev = 1; wait_cnt = 0; cyc = 0; owner_data = 0;
    last_we = 0; last_addr = 0; last_wdata = 0; last_wstrb = 0;
    forever begin
      @(posedge clock);
      s_i_req = bus.i_req;   s_i_addr = bus.i_addr;
      s_d_req = bus.d_req;   s_d_we = bus.d_we;   s_d_addr = bus.d_addr;
      s_d_wdata = bus.d_wdata; s_d_wstrb = bus.d_wstrb; s_m_done = bus.m_done;
      #1;
      cyc++;
      if (!reset) begin
        check("rst_m_req", bus.m_req, 0);
        check("rst_acks", {bus.i_ack, bus.d_ack}, 0);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        check("rst_cmd", {bus.m_we, bus.m_addr, bus.m_wstrb}, 0);
        exp_i.delete();
        exp_d.delete();
        last_m_req = 0; last_ack = 0; idle_prev = 1; wait_cnt = 0;
        continue;
      end
      new_iss = bus.m_req && !last_m_req;
      exp_ack = last_m_req && s_m_done;
      check("ack_timing", bus.i_ack | bus.d_ack, exp_ack);
      check("ack_excl", bus.i_ack & bus.d_ack, 0);
      if (exp_ack) check("ack_owner", bus.d_ack, owner_data);
      if (bus.i_ack) begin
        if (exp_i.size() == 0) check("i_ack_spurious", 1, 0);
        else check("i_rdata", bus.i_rdata, exp_i.pop_front());
      end
      if (bus.d_ack) begin
        if (exp_d.size() == 0) check("d_ack_spurious", 1, 0);
        else check("d_rdata", bus.d_rdata, exp_d.pop_front());
      end
      if (idle_prev && (s_i_req || s_d_req)) check("issue_when_idle", bus.m_req, 1);
      if (new_iss) begin
        check("issue_while_not_idle", idle_prev, 1);
        if (!s_i_req && !s_d_req) check("issue_without_req", 1, 0);
        want_data = s_d_req && !(s_i_req && wait_cnt >= LIM);
        if (want_data) begin
          check("grant_data_we", bus.m_we, s_d_we);
          check("grant_data_addr", bus.m_addr, s_d_addr);
          check("grant_data_wdata", bus.m_wdata, s_d_wdata);
          check("grant_data_wstrb", bus.m_wstrb, s_d_wstrb);
          wait_cnt = s_i_req ? ((wait_cnt < LIM) ? wait_cnt + 1 : LIM) : 0;
        end else begin
          check("grant_fetch_we", bus.m_we, 0);
          check("grant_fetch_addr", bus.m_addr, s_i_addr);
          check("grant_fetch_wstrb", bus.m_wstrb, 0);
          wait_cnt = 0;
        end
        owner_data = want_data;
        grant_log.push_back(want_data);
        issue_cyc.push_back(cyc);
      end
      if (bus.m_req && last_m_req) begin
        check("hold_we", bus.m_we, last_we);
        check("hold_addr", bus.m_addr, last_addr);
        check("hold_wdata", bus.m_wdata, last_wdata);
        check("hold_wstrb", bus.m_wstrb, last_wstrb);
      end
      if (bus.m_req) mreq_cycles++;
      check("i_stall", bus.i_stall, s_i_req & ~bus.i_ack);
      check("d_stall", bus.d_stall, s_d_req & ~bus.d_ack);
      idle_now = last_ack || (idle_prev && !bus.m_req);
      idle_prev = idle_now;
      last_ack = bus.i_ack | bus.d_ack;
      last_m_req = bus.m_req;
      last_we = bus.m_we; last_addr = bus.m_addr;
      last_wdata = bus.m_wdata; last_wstrb = bus.m_wstrb;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ones;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;

    repeat (3) @(negedge clock);
    check("reset_m_req", bus.m_req, 0);
    check("reset_acks", {bus.i_ack, bus.d_ack}, 0);
    check("reset_m_fields", {bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb}, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single fetch, zero-wait memory.
    mem_lat = 0;
    ref_mem[4] = 32'h13;
    dev_mem[4] = 32'h13;
    do_fetch(32'h10);
    check("single_fetch_rdata", bus.i_rdata, 32'h13);
    @(negedge clock);

    // Contention: write wins, fetch issues 3 cycles later.
    issue_cyc.delete();
    fork
      do_data(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      do_fetch(32'h20);
    join
    check("contention_issues", issue_cyc.size(), 2);
    if (issue_cyc.size() == 2) check("contention_gap", issue_cyc[1] - issue_cyc[0], 3);
    check("contention_d_rdata", bus.d_rdata, 0);
    @(negedge clock);

    // Starvation guard.
    grant_log.delete();
    fork
      do_fetch(32'h40);
      for (int i = 0; i < 6; i++) do_data(1'b0, 32'h1000_0000 + 32'(i * 4), 0, 0);
    join
    ones = 0;
    while (ones < grant_log.size() && grant_log[ones]) ones++;
    check("starve_data_grants", ones, LIM);
    check("starve_then_fetch", (grant_log.size() > LIM) ? grant_log[LIM] : 1'b1, 0);
    @(negedge clock);

    // Long latency: m_req high for 7 cycles.
    mem_lat = 6;
    mreq_cycles = 0;
    do_fetch(32'h80);
    check("long_mreq_cycles", mreq_cycles, 7);
    @(negedge clock);

    // Reset during the second BUSY cycle of a data read.
    mem_lat = 20;
    bus.d_we = 0; bus.d_addr = 32'h1000_0040; bus.d_req = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.m_req && n < 20) begin @(negedge clock); n++; end
    end
    check("rst_mid_issue", bus.m_req, 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_m_req_drop", bus.m_req, 0);
    check("rst_mid_no_d_ack", bus.d_ack, 0);
    bus.d_req = 1'b0;
    exp_d_last = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    mem_lat = 1;
    do_fetch(32'h0C4);
    @(negedge clock);

    // Zero-wait back-to-back fetches.
    mem_lat = 0;
    issue_cyc.delete();
    for (int i = 0; i < 10; i++) do_fetch(32'h200 + 32'(i * 4));
    check("b2b_issues", issue_cyc.size(), 10);
    for (int k = 1; k < issue_cyc.size(); k++)
      check("b2b_gap", issue_cyc[k] - issue_cyc[k-1], 3);
    @(negedge clock);

    // Randomized traffic with random memory latency.
    mem_lat = -1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        do_fetch({20'h0, 10'($urandom), 2'b00});
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        do_data(1'($urandom), 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2),
                $urandom, 4'($urandom_range(0, 15)));
      end
    join
    repeat (3) @(negedge clock);
    check("exp_i_drained", exp_i.size(), 0);
    check("exp_d_drained", exp_d.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
